regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
// Parametrised multi-port integer register file for the pipelined LEGv8 datapath.
// Generalises the 2R/1W, 32x64 file to NREAD read ports and NWRITE write ports.
// Adds async reset, optional write-to-read bypass, and a deterministic write-conflict rule.
// Sits in ID (reads) and WB (writes); the hardwired-zero register (XZR) stays read-only.
// PARAMETERS
// WIDTH     64  data width of each register, in bits
// DEPTH     32  number of registers; power of two; AW = $clog2(DEPTH)
// NREAD      2  number of read ports, >= 1
// NWRITE     1  number of write ports, >= 1
// ZERO_REG  31  index that always reads 0 and ignores writes; -1 disables the zero register
// BYPASS     1  1 = same-cycle write data is forwarded to matching reads; 0 = reads see old value
// PORTS
// clk    in   1                clock; all writes happen on the rising edge
// rst_n  in   1                asynchronous reset, active low
// ra     in   [NREAD][AW]      read addresses
// rd     out  [NREAD][WIDTH]   read data, combinational from ra/state (and bypass)
// we     in   [NWRITE]         write enables
// wa     in   [NWRITE][AW]     write addresses
// wd     in   [NWRITE][WIDTH]  write data
// BEHAVIOUR
// - Reset: rst_n low clears every register to 0 immediately, without waiting for clk.
//   rd follows the cleared state combinationally. Writes are ignored while rst_n is low.
//   The first write can land on the first rising edge after rst_n rises.
// - Write: on posedge clk, each port p with we[p]=1 and wa[p]!=ZERO_REG loads mem[wa[p]] <= wd[p].
//   Write latency is 1 cycle.
// - Write conflict: if several enabled ports target the same address, the highest port index wins.
//   The other ports' data is dropped silently. There is no error output.
// - Read: rd[r] = 0 when ra[r]==ZERO_REG; otherwise rd[r] = mem[ra[r]].
//   Reads are combinational (0-cycle latency) and never blocked.
// - Bypass (BYPASS=1): if some enabled port p has wa[p]==ra[r] and ra[r]!=ZERO_REG,
//   rd[r] = wd[p] in the same cycle. The highest such p wins, matching the commit rule.
//   Bypass is gated by rst_n; while in reset, rd = 0.
// - Bypass (BYPASS=0): rd shows the pre-edge value until the clock edge commits the write.
// - Simultaneous events: read and write of the same register in one cycle are legal.
//   With BYPASS=1 the read returns the new value. Reads of other registers are unaffected.
// - Zero register: writes to ZERO_REG are discarded and rd reads 0, including through the bypass path.
// - Width rules: no truncation or extension. wd and rd are exactly WIDTH bits.
//   Out-of-range addresses cannot occur because DEPTH = 2^AW.
// - Elaboration: $error if DEPTH is not a power of two, NREAD<1, NWRITE<1,
//   or ZERO_REG is outside -1..DEPTH-1.
// STRUCTURE
// - regfile_pkg: localparam XZR=31; function automatic addr_w(depth) returning $clog2;
//   typedef logic [63:0] word_t for the default datapath.
// - Sub-module regfile_wsel: per-address write resolver. It is purely combinational.
//   Inputs: we/wa/wd. Outputs: a hit flag and the winning data, highest port first.
//   The same resolver serves commit and bypass, so the priority rule exists in exactly one place.
// - Top level: storage array always_ff @(posedge clk or negedge rst_n), plus generate loops over read ports.
// TESTING
// 1 Reset: fill all registers with i+1, pulse rst_n low mid-cycle -> every rd=0 before the next posedge;
//   writes during reset have no effect.
// 2 Sweep: write 100+i to X0..X30, then read all 32 on both ports -> rd=100+i; X31 reads 0.
// 3 XZR: we=1, wa=31, wd=75 -> rd(ra=31)=0 both before and after the edge.
// 4 Bypass: X6=69; in one cycle write wd=71 to X6 with ra=6 -> BYPASS=1 gives rd=71 same cycle;
//   BYPASS=0 gives 69, then 71 after the edge.
// 5 Conflict (NWRITE=2): port0 writes X5=10 and port1 writes X5=20 in the same cycle
//   -> bypass shows 20 and X5=20 after the edge.
// 6 we=0: X6=71, wd=72, wa=6, we=0 for 3 cycles -> rd stays 71. Repeat with NREAD=4, WIDTH=32.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port LEGv8 register file.
package regfile_pkg;

    localparam int XZR = 31;

    typedef logic [63:0] word_t;

    // Address width for a given depth; never below 1 so port vectors stay legal.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_wsel.sv
// Write resolver: for one address, reports whether any enabled write port targets it
// and which data wins (highest port index). Shared by the commit and bypass paths.
module regfile_wsel
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int AW     = 5,
    parameter int NWRITE = 1
) (
    input  logic [AW-1:0]                  addr_i,
    input  logic [NWRITE-1:0]              we_i,
    input  logic [NWRITE-1:0][AW-1:0]      wa_i,
    input  logic [NWRITE-1:0][WIDTH-1:0]   wd_i,
    output logic                           hit_o,
    output logic [WIDTH-1:0]               data_o
);

    // Ascending scan: a later (higher) port overrides any earlier match.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int p = 0; p < NWRITE; p++) begin
            if (we_i[p] && (wa_i[p] == addr_i)) begin
                hit_o  = 1'b1;
                data_o = wd_i[p];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised NREAD/NWRITE register file with async clear, optional same-cycle
// write-to-read bypass and a read-only zero register.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = XZR,
    parameter int BYPASS   = 1,
    localparam int AW      = addr_w(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NREAD-1:0][AW-1:0]       ra,
    output logic [NREAD-1:0][WIDTH-1:0]    rd,
    input  logic [NWRITE-1:0]              we,
    input  logic [NWRITE-1:0][AW-1:0]      wa,
    input  logic [NWRITE-1:0][WIDTH-1:0]   wd
);

    localparam bit            ZR_EN   = (ZERO_REG >= 0);
    localparam logic [AW-1:0] ZR_ADDR = AW'(ZR_EN ? ZERO_REG : 0);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("regfile_mp: DEPTH (%0d) must be a power of two >= 2", DEPTH);
    end
    if (NREAD < 1) begin : g_bad_nread
        $error("regfile_mp: NREAD (%0d) must be >= 1", NREAD);
    end
    if (NWRITE < 1) begin : g_bad_nwrite
        $error("regfile_mp: NWRITE (%0d) must be >= 1", NWRITE);
    end
    if ((ZERO_REG < -1) || (ZERO_REG > DEPTH - 1)) begin : g_bad_zero
        $error("regfile_mp: ZERO_REG (%0d) outside -1..DEPTH-1", ZERO_REG);
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] commit_hit;
    logic [WIDTH-1:0] commit_data [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_commit
        logic             hit;
        logic [WIDTH-1:0] data;

        regfile_wsel #(
            .WIDTH  (WIDTH),
            .AW     (AW),
            .NWRITE (NWRITE)
        ) u_wsel (
            .addr_i (AW'(gi)),
            .we_i   (we),
            .wa_i   (wa),
            .wd_i   (wd),
            .hit_o  (hit),
            .data_o (data)
        );

        // The zero register never commits, so its storage stays at the reset value.
        assign commit_hit[gi]  = hit && !(ZR_EN && (gi == ZERO_REG));
        assign commit_data[gi] = data;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = commit_hit[i] ? commit_data[i] : mem_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar gr = 0; gr < NREAD; gr++) begin : g_rd
        logic             rd_zero;
        logic             byp_hit;
        logic [WIDTH-1:0] byp_data;

        assign rd_zero = ZR_EN && (ra[gr] == ZR_ADDR);

        if (BYPASS != 0) begin : g_byp
            regfile_wsel #(
                .WIDTH  (WIDTH),
                .AW     (AW),
                .NWRITE (NWRITE)
            ) u_byp (
                .addr_i (ra[gr]),
                .we_i   (we),
                .wa_i   (wa),
                .wd_i   (wd),
                .hit_o  (byp_hit),
                .data_o (byp_data)
            );
        end else begin : g_nobyp
            assign byp_hit  = 1'b0;
            assign byp_data = '0;
        end

        // Bypass is masked in reset so rd tracks the cleared array immediately.
        assign rd[gr] = rd_zero               ? '0       :
                        (byp_hit && rst_n)    ? byp_data :
                                                mem_q[ra[gr]];
    end

endmodule
